ram_sdp_be: RTL
===============

// Module: ram_sdp_be
// PURPOSE
//  Parametrised simple-dual-port RAM: one write port with byte enables, one read port with
//  configurable read latency, built-in clear sequencer and out-of-range address flagging.
//  Drop-in storage for buffers/tables that need byte writes and a clean, known memory state
//  after every reset or on software demand. Flat ports (no interface) for easy instantiation.
// PARAMETERS
//  D_WIDTH       32            data width in bits; must be a multiple of 8
//  A_WIDTH       8             address width
//  DEPTH         2**A_WIDTH    number of words; 1..2**A_WIDTH (non-power-of-2 allowed)
//  READ_LATENCY  1             cycles from accepted read_en to read_valid; legal values 1 or 2
//  INIT_VALUE    '0            D_WIDTH-bit value written to every word by the clear sequencer
// PORTS
//  clk          in   1             single clock, all logic on posedge
//  rst          in   1             asynchronous reset, active-low
//  clear_req    in   1             pulse: re-clear whole memory (accepted only when ready=1)
//  write_en     in   1             write request (accepted only when ready=1)
//  write_addr   in   A_WIDTH       write word address
//  write_data   in   D_WIDTH       write data
//  write_be     in   D_WIDTH/8     byte enables; bit i covers write_data[8i+7:8i]
//  read_en      in   1             read request (accepted only when ready=1)
//  read_addr    in   A_WIDTH       read word address
//  read_data    out  D_WIDTH       read data; 0 whenever read_valid=0
//  read_valid   out  1             1-cycle pulse per accepted read, READ_LATENCY after accept
//  ready        out  1             1 = idle, requests accepted; 0 = clear in progress
//  addr_err     out  1             1-cycle pulse, same cycle as request acceptance, on out-of-range addr
// BEHAVIOUR
//  - rst=0 (async): read_data=0, read_valid=0, addr_err=0, ready=0, read pipeline flushed,
//    FSM->CLEAR, clear counter=0. Memory contents undefined until CLEAR completes.
//  - FSM (states in package): CLEAR, RUN.
//    CLEAR: writes INIT_VALUE to word cnt each cycle, cnt 0..DEPTH-1; exactly DEPTH cycles;
//    ready=0; write_en/read_en/clear_req ignored (dropped, no addr_err). cnt==DEPTH-1 -> RUN.
//    RUN: ready=1; clear_req=1 -> CLEAR next cycle (write_en/read_en in that cycle still accepted).
//  - rst asserted mid-CLEAR: restart from word 0 after release.
//  - Write: accepted at posedge; bytes with write_be[i]=1 updated, others kept. write_be=0 -> no-op.
//  - Read: memory array read at accept edge. Latency 1: data registered once. Latency 2:
//    extra output register stage. read_valid/read_data for in-flight reads complete normally
//    even if CLEAR starts meanwhile (data already captured).
//  - Back-to-back reads every cycle: full throughput, one read_valid per accepted read_en.
//  - Same-cycle read and write to same address: see CONFIGURATION.
//  - Out-of-range (addr >= DEPTH): write dropped; read still produces read_valid with read_data=0;
//    addr_err pulses once per offending request (write and read both bad -> single pulse).
//  - Widths: write_be is D_WIDTH/8; elaboration error if D_WIDTH%8!=0, READ_LATENCY not 1/2,
//    or DEPTH>2**A_WIDTH.
// CONFIGURATION
//  RAM_BYPASS_EN defined: same-address read+write in one cycle returns write-first data,
//    byte-merged (enabled bytes = write_data, others = old word).
//  RAM_BYPASS_EN undefined: read-first; read returns old word; new data visible from next read.
// STRUCTURE
//  - Package ram_pkg: state enum ram_state_e {CLEAR, RUN}; localparam BE_WIDTH=D_WIDTH/8 helper
//    function; shared byte-merge function merge_be(old, new, be).
//  - Sub-module ram_clear_seq: CLEAR/RUN FSM + address counter; outputs ready, clr_we, clr_addr.
//  - Top: memory array, write mux (clear vs user), read pipeline, addr_err logic.
// TESTING
//  1. Reset release, DEPTH=256, INIT_VALUE=32'hA5A5A5A5 -> ready=0 for exactly 256 cycles;
//     then read addr 0,255 -> read_data=A5A5A5A5, read_valid READ_LATENCY cycles after accept.
//  2. Write 0x11223344 be=4'b1111 to addr 5, then 0xFFFFFFFF be=4'b0101 -> read 5 gives 0x11FF33FF.
//  3. Same cycle write 0xDEADBEEF be=F and read addr 9 (old 0) -> read_data 0 without
//     RAM_BYPASS_EN, 0xDEADBEEF with it; next read of 9 gives 0xDEADBEEF in both builds.
//  4. DEPTH=200: write addr 210, read addr 210 -> addr_err pulse; read_valid=1, read_data=0;
//     addr 210 aliasing check: read addr 10 unchanged.
//  5. Reads issued 1 cycle before clear_req, READ_LATENCY=2 -> both reads return valid data;
//     ready drops next cycle; write_en during CLEAR ignored (memory = INIT_VALUE afterwards).
//  6. rst pulsed low at CLEAR cycle 100 -> outputs zero immediately; clear restarts, full DEPTH cycles.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared state type and byte-enable helpers for the simple-dual-port RAM.
package ram_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } ram_state_e;

    // Upper bound on data width handled by the shared merge helper.
    localparam int unsigned MAX_D_WIDTH  = 1024;
    localparam int unsigned MAX_BE_WIDTH = MAX_D_WIDTH / 8;

    function automatic int unsigned be_width(input int unsigned d_width);
        return d_width / 8;
    endfunction

    function automatic logic [MAX_D_WIDTH-1:0] merge_be(
        input logic [MAX_D_WIDTH-1:0]  old_word,
        input logic [MAX_D_WIDTH-1:0]  new_word,
        input logic [MAX_BE_WIDTH-1:0] be
    );
        logic [MAX_D_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < int'(MAX_BE_WIDTH); i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: CLEAR/RUN FSM plus word counter that walks the whole array once
// after reset or on a clear request.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int unsigned A_WIDTH = 8,
    parameter int unsigned DEPTH   = 256
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clear_req,
    output logic               o_ready,
    output logic               o_clr_we,
    output logic [A_WIDTH-1:0] o_clr_addr
);

    localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(DEPTH - 1);

    ram_state_e         r_state;
    ram_state_e         w_state_nxt;
    logic [A_WIDTH-1:0] r_cnt;
    logic [A_WIDTH-1:0] w_cnt_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            CLEAR: begin
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RUN: begin
                if (i_clear_req) begin
                    w_state_nxt = CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        o_ready    = (r_state == RUN);
        o_clr_we   = (r_state == CLEAR);
        o_clr_addr = r_cnt;
    end

endmodule

// File: rtl/ram_sdp_be.sv
// Simple-dual-port RAM with byte-enable writes, 1/2-cycle reads, clear sequencer and
// out-of-range flagging. Define RAM_BYPASS_EN for write-first same-address reads.
module ram_sdp_be
    import ram_pkg::*;
#(
    parameter int unsigned        D_WIDTH      = 32,
    parameter int unsigned        A_WIDTH      = 8,
    parameter int unsigned        DEPTH        = 2 ** A_WIDTH,
    parameter int unsigned        READ_LATENCY = 1,
    parameter logic [D_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear_req,
    input  logic                 i_write_en,
    input  logic [A_WIDTH-1:0]   i_write_addr,
    input  logic [D_WIDTH-1:0]   i_write_data,
    input  logic [D_WIDTH/8-1:0] i_write_be,
    input  logic                 i_read_en,
    input  logic [A_WIDTH-1:0]   i_read_addr,
    output logic [D_WIDTH-1:0]   o_read_data,
    output logic                 o_read_valid,
    output logic                 o_ready,
    output logic                 o_addr_err
);

    localparam int unsigned      BE_WIDTH = be_width(D_WIDTH);
    localparam int unsigned      IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [A_WIDTH:0] DEPTH_L  = (A_WIDTH + 1)'(DEPTH);

    if (D_WIDTH % 8 != 0 || D_WIDTH == 0 || D_WIDTH > MAX_D_WIDTH) begin : g_err_dwidth
        $error("ram_sdp_be: D_WIDTH must be a non-zero multiple of 8 within MAX_D_WIDTH");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_err_latency
        $error("ram_sdp_be: READ_LATENCY must be 1 or 2");
    end
    if (DEPTH == 0 || DEPTH > 2 ** A_WIDTH) begin : g_err_depth
        $error("ram_sdp_be: DEPTH must be in 1..2**A_WIDTH");
    end

    logic                 w_ready;
    logic                 w_clr_we;
    logic [A_WIDTH-1:0]   w_clr_addr;
    logic [IDX_W-1:0]     w_clr_idx;
    logic [IDX_W-1:0]     w_wr_idx;
    logic [IDX_W-1:0]     w_rd_idx;
    logic                 w_wr_acc;
    logic                 w_rd_acc;
    logic                 w_wr_in_range;
    logic                 w_rd_in_range;
    logic                 w_wr_ok;
    logic [D_WIDTH-1:0]   w_wr_old;
    logic [D_WIDTH-1:0]   w_wr_merged;
    logic [D_WIDTH-1:0]   w_rd_word;
    logic [D_WIDTH-1:0]   w_rd_value;
    logic [D_WIDTH-1:0]   r_mem [DEPTH];
    logic                 r_rd1_valid;
    logic [D_WIDTH-1:0]   r_rd1_data;

    ram_clear_seq #(
        .A_WIDTH (A_WIDTH),
        .DEPTH   (DEPTH)
    ) u_clear_seq (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear_req (i_clear_req),
        .o_ready     (w_ready),
        .o_clr_we    (w_clr_we),
        .o_clr_addr  (w_clr_addr)
    );

    assign w_clr_idx     = w_clr_addr[IDX_W-1:0];
    assign w_wr_idx      = i_write_addr[IDX_W-1:0];
    assign w_rd_idx      = i_read_addr[IDX_W-1:0];
    assign w_wr_acc      = w_ready & i_write_en;
    assign w_rd_acc      = w_ready & i_read_en;
    assign w_wr_in_range = ({1'b0, i_write_addr} < DEPTH_L);
    assign w_rd_in_range = ({1'b0, i_read_addr} < DEPTH_L);
    assign w_wr_ok       = w_wr_acc & w_wr_in_range;

    assign w_wr_old    = r_mem[w_wr_idx];
    assign w_wr_merged = D_WIDTH'(merge_be(MAX_D_WIDTH'(w_wr_old), MAX_D_WIDTH'(i_write_data),
                                           MAX_BE_WIDTH'(i_write_be)));

`ifdef RAM_BYPASS_EN
    logic w_bypass;
    // Write-first: a same-address read sees the byte-merged word being written.
    assign w_bypass  = w_wr_ok & (i_write_addr == i_read_addr);
    assign w_rd_word = w_bypass ? w_wr_merged : r_mem[w_rd_idx];
`else
    assign w_rd_word = r_mem[w_rd_idx];
`endif

    assign w_rd_value = w_rd_in_range ? w_rd_word : '0;

    // Single pulse even when both ports carry a bad address in the same cycle.
    assign o_addr_err = (w_wr_acc & ~w_wr_in_range) | (w_rd_acc & ~w_rd_in_range);
    assign o_ready    = w_ready;

    always_ff @(posedge i_clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_idx] <= INIT_VALUE;
        end else if (w_wr_ok) begin
            r_mem[w_wr_idx] <= w_wr_merged;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd1_valid <= 1'b0;
            r_rd1_data  <= '0;
        end else begin
            r_rd1_valid <= w_rd_acc;
            r_rd1_data  <= w_rd_acc ? w_rd_value : '0;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic               r_rd2_valid;
        logic [D_WIDTH-1:0] r_rd2_data;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_rd2_valid <= 1'b0;
                r_rd2_data  <= '0;
            end else begin
                r_rd2_valid <= r_rd1_valid;
                r_rd2_data  <= r_rd1_data;
            end
        end

        assign o_read_valid = r_rd2_valid;
        assign o_read_data  = r_rd2_data;
    end else begin : g_lat1
        assign o_read_valid = r_rd1_valid;
        assign o_read_data  = r_rd1_data;
    end

endmodule
